serial_paralelo_rx: RTL and testbench
=====================================

# serial_paralelo_rx

Single-clock serial-to-parallel receiver for the RX path, feeding lane words to the two-lane unstriping mux.
- Shifts in a 1-bit stream at 32× the lane rate.
- Acquires word alignment from a run of reserved idle words.
- Emits each 32-bit word with a valid flag: idle words come out with valid=0, data words with valid=1.
- One instance per lane; its `data_out`/`valid_out` drive one `data_inN`/`valid_inN` pair of the mux.

## Interface
Parameters:
- `IDLE_WORD`, default 32'hBCBCBCBC: reserved idle/comma word; never carries data.
- `LOCK_WORDS`, default 4: consecutive aligned idle words required to declare lock (legal range 1–15).

Ports:
- `clk_32f` input 1: the only clock, bit rate; all logic on posedge.
- `reset_L` input 1: reset, asynchronous and active-low.
- `data_in` input 1: serial bit, MSB of each word first.
- `data_out` output 32: last received word, held between word boundaries.
- `valid_out` output 1: 1 when `data_out` is a data word (≠ `IDLE_WORD`) received while ACTIVE.
- `word_strobe` output 1: one-cycle pulse when `data_out`/`valid_out` update.
- `active` output 1: 1 while in ACTIVE (locked).

## Operation
- Shift register `sr[31:0]` updates on every edge: `sr <= {sr[30:0], data_in}`.
- Received word `w = {sr[30:0], data_in}`, i.e. the 32 most recent bits including the bit sampled at this edge. All word decisions use `w`.
- `bit_cnt` is 5 bits and wraps 31→0. `good` is a 4-bit count of idle words.

State machine, encoded in 2 bits:
- **SEARCH** (reset state): checks every edge, any bit offset.
  - If `w == IDLE_WORD`: next state is CHECK, `bit_cnt <= 0`, `good <= 1`.
  - If additionally `LOCK_WORDS == 1`: go directly to ACTIVE, with `bit_cnt <= 0`.
- **CHECK**: `bit_cnt` increments every edge. On the edge where `bit_cnt == 31`:
  - If `w == IDLE_WORD`: `good <= good + 1`; if `good + 1 == LOCK_WORDS`, next state is ACTIVE.
  - If `w != IDLE_WORD`: next state is SEARCH, `good <= 0`.
  - On other edges: no decision.
- **ACTIVE**: `bit_cnt` increments every edge. On the edge where `bit_cnt == 31`:
  - `data_out <= w`.
  - `valid_out <= (w != IDLE_WORD)`.
  - `word_strobe <= 1`.
  - On all other edges `word_strobe <= 0`; `data_out` and `valid_out` hold.
- Lock is sticky: ACTIVE exits only via `reset_L`. Idle words in ACTIVE are legal gaps (valid=0), not errors.
- `active` is 1 exactly while state == ACTIVE. `data_out`, `valid_out` and `word_strobe` do not change in SEARCH or CHECK.

## Timing
- Reset values: `data_out` = 0, `valid_out` = 0, `word_strobe` = 0, `active` = 0, `sr` = 0, `bit_cnt` = 0, `good` = 0, state = SEARCH.
- Reset is asynchronous. Asserting it mid-word clears everything immediately; the partial word is discarded and acquisition restarts after release.
- Lock time from the first aligned idle word's last bit:
  - the edge sampling the last bit of idle word k (k = 1..LOCK_WORDS) is edge `(k−1)·32` relative to that first edge;
  - ACTIVE is entered after edge `(LOCK_WORDS−1)·32`.
- Output latency: `data_out`/`valid_out` are updated at the edge sampling a word's last bit, and are visible from that edge until the next strobe, i.e. 32 cycles.
- `word_strobe` period is exactly 32 cycles in ACTIVE. It is high during the cycle following each update edge.
- The consumer samples on the lane clock (`clk_32f`/32). Phase alignment of the lane clock to `word_strobe` is the system's responsibility.
- In SEARCH, a misaligned stream that happens to contain the `IDLE_WORD` pattern triggers CHECK. Subsequent word checks reject a false alignment within 32 cycles.

## Test plan
- **Reset:** hold `reset_L = 0` for 3 cycles, driving random `data_in` → all outputs 0, state SEARCH. Assert `reset_L` low mid-word while ACTIVE → `active`, `valid_out` and `data_out` drop to 0 immediately.
- **Acquisition:** after reset, send 5 bits of noise, then 4× 0xBCBCBCBC → `active` rises at the edge of the 128th idle bit. `valid_out` stays 0 throughout.
- **Data path:** once locked, send 0xEEEEEEEE, 0xEEEEEEEF, then idle → at consecutive strobes `data_out` = 0xEEEEEEEE (valid 1), 0xEEEEEEEF (valid 1), 0xBCBCBCBC (valid 0). Strobes are exactly 32 cycles apart.
- **Failed lock:** send 2 idle words, then 0x12345678, then 4 idle words → CHECK returns to SEARCH at the 0x12345678 boundary. `active` rises only after the last 4 idles.
- **Gaps:** with lanes feeding the mux, interleave data/idle in the pattern 2 data, 2 idle, 2 data → the `valid_out` sequence is 1,1,0,0,1,1. `active` stays 1.
- **Parameter:** `LOCK_WORDS = 1` → `active` rises at the end of the first idle word.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: 1-bit serial to 32-bit word receiver for one RX lane.
// Finds word alignment from a run of reserved idle words and, once locked,
// emits every received word with a valid flag (idle words come out invalid).
//
// Handshake: there is no back-pressure. word_strobe is a one-cycle pulse
// marking the cycle in which data_out/valid_out hold a freshly received word;
// the consumer must take the word before the next strobe, 32 cycles later.
module serial_paralelo_rx #(
  parameter logic [31:0] IDLE_WORD  = 32'hBCBCBCBC,
  parameter int          LOCK_WORDS = 4
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic        data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        word_strobe,
  output logic        active,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] sr;
  logic [4:0]  bit_cnt;
  logic [3:0]  good;
  logic [3:0]  good_inc;
  logic [31:0] w;
  logic        w_idle;
  logic        at_end;

  // Word formed by the 31 previous bits plus the bit sampled at this edge.
  assign w        = {sr[30:0], data_in};
  assign w_idle   = (w == IDLE_WORD);
  assign at_end   = (bit_cnt == 5'd31);
  assign good_inc = good + 4'd1;

  // State register.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: SEARCH hunts any bit offset, CHECK confirms at word
  // boundaries, ACTIVE is sticky until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: begin
        if (w_idle) begin
          state_nxt = (LOCK_WORDS == 1) ? ACTIVE : CHECK;
        end
      end
      CHECK: begin
        if (at_end) begin
          if (!w_idle) begin
            state_nxt = SEARCH;
          end else if (good_inc == LOCK_N) begin
            state_nxt = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        state_nxt = ACTIVE;
      end
      default: begin
        state_nxt = SEARCH;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    active    = (state == ACTIVE);
    fsm_state = state;
  end

  // Shift register, bit counter and idle-word counter.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr      <= 32'd0;
      bit_cnt <= 5'd0;
      good    <= 4'd0;
    end else begin
      sr <= w;
      case (state)
        SEARCH: begin
          if (w_idle) begin
            bit_cnt <= 5'd0;
            good    <= 4'd1;
          end
        end
        CHECK: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (at_end) begin
            good <= w_idle ? good_inc : 4'd0;
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 5'd1;
        end
        default: begin
          bit_cnt <= 5'd0;
          good    <= 4'd0;
        end
      endcase
    end
  end

  // Word output registers: load at each word boundary while locked only.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      data_out    <= 32'd0;
      valid_out   <= 1'b0;
      word_strobe <= 1'b0;
    end else begin
      word_strobe <= (state == ACTIVE) && at_end;
      if ((state == ACTIVE) && at_end) begin
        data_out  <= w;
        valid_out <= !w_idle;
      end
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx. Two instances (lock after 4 idle words and
// after 1 idle word) receive the same serial stream. Expectations come from a
// stream-level reference model that scans the recorded bit history for the
// lock point and derives every word boundary from it arithmetically.
module tb_serial_paralelo_rx;

  localparam logic [31:0] IDLE = 32'hBCBCBCBC;

  logic        clk;
  logic        reset_L;
  logic        data_in;
  logic [31:0] d4, d1;
  logic        v4, v1, s4, s1, a4, a1;
  logic [1:0]  st4, st1;

  int test_count = 0;
  int fail_count = 0;

  bit stream_q[$];

  serial_paralelo_rx #(.IDLE_WORD(IDLE), .LOCK_WORDS(4)) dut (
    .clk_32f(clk), .reset_L(reset_L), .data_in(data_in),
    .data_out(d4), .valid_out(v4), .word_strobe(s4), .active(a4),
    .fsm_state(st4)
  );

  serial_paralelo_rx #(.IDLE_WORD(IDLE), .LOCK_WORDS(1)) dut1 (
    .clk_32f(clk), .reset_L(reset_L), .data_in(data_in),
    .data_out(d1), .valid_out(v1), .word_strobe(s1), .active(a1),
    .fsm_state(st1)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // 32 most recent bits ending at edge e (bits before reset release are 0).
  function automatic logic [31:0] window(int e);
    logic [31:0] r;
    int idx;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      idx = e - 31 + i;
      r = {r[30:0], (idx >= 0 && idx < stream_q.size()) ? stream_q[idx] : 1'b0};
    end
    return r;
  endfunction

  // Edge index at which lock is declared, or -1 if the stream never locks.
  function automatic int find_lock(int lw);
    int pos, n, e, b;
    bit ok;
    n = stream_q.size();
    pos = 0;
    while (pos < n) begin
      e = -1;
      for (int i = pos; i < n; i++) begin
        if (window(i) == IDLE) begin
          e = i;
          break;
        end
      end
      if (e < 0) return -1;
      ok = 1'b1;
      for (int k = 1; k < lw; k++) begin
        b = e + 32 * k;
        if (b >= n) return -1;
        if (window(b) != IDLE) begin
          pos = b + 1;
          ok = 1'b0;
          break;
        end
      end
      if (ok) return e + 32 * (lw - 1);
    end
    return -1;
  endfunction

  // Outputs expected right after edge e, given the lock edge.
  task automatic expect_at(input int lock, input int e, output logic act,
                           output logic strb, output logic vld,
                           output logic [31:0] dat);
    int last;
    act = (lock >= 0) && (e >= lock);
    strb = act && (e > lock) && ((e - lock) % 32 == 0);
    dat = 32'd0;
    vld = 1'b0;
    if (act && (e - lock) >= 32) begin
      last = lock + 32 * ((e - lock) / 32);
      dat = window(last);
      vld = (dat != IDLE);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [31:0] wd);
    for (int i = 31; i >= 0; i--) stream_q.push_back(wd[i]);
  endtask

  task automatic push_noise(input int n);
    for (int i = 0; i < n; i++) stream_q.push_back(1'($urandom_range(0, 1)));
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] r;
    r = $urandom;
    if (r == IDLE) r = r ^ 32'h1;
    return r;
  endfunction

  // Reset for 3 cycles with random serial input; ends at a negedge, released.
  task automatic do_reset();
    reset_L = 1'b0;
    repeat (3) begin
      @(negedge clk);
      data_in = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    check_val("rst_data4", d4, 32'd0);
    check_val("rst_valid4", {31'd0, v4}, 32'd0);
    check_val("rst_strobe4", {31'd0, s4}, 32'd0);
    check_val("rst_active4", {31'd0, a4}, 32'd0);
    check_val("rst_state4", {30'd0, st4}, 32'd0);
    check_val("rst_active1", {31'd0, a1}, 32'd0);
    check_val("rst_state1", {30'd0, st1}, 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
    stream_q.delete();
  endtask

  // Drive the recorded stream one bit per cycle and check every edge.
  task automatic run_stream();
    int lock4, lock1;
    logic act, strb, vld;
    logic [31:0] dat;
    lock4 = find_lock(4);
    lock1 = find_lock(1);
    for (int e = 0; e < stream_q.size(); e++) begin
      data_in = stream_q[e];
      @(posedge clk);
      #1;
      expect_at(lock4, e, act, strb, vld, dat);
      check_val("active4", {31'd0, a4}, {31'd0, act});
      check_val("strobe4", {31'd0, s4}, {31'd0, strb});
      check_val("valid4", {31'd0, v4}, {31'd0, vld});
      check_val("data4", d4, dat);
      expect_at(lock1, e, act, strb, vld, dat);
      check_val("active1", {31'd0, a1}, {31'd0, act});
      check_val("strobe1", {31'd0, s1}, {31'd0, strb});
      check_val("valid1", {31'd0, v1}, {31'd0, vld});
      check_val("data1", d1, dat);
      @(negedge clk);
    end
  endtask

  // Asynchronous reset in the middle of a clock cycle while locked.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    reset_L = 1'b0;
    #1;
    check_val("mid_active4", {31'd0, a4}, 32'd0);
    check_val("mid_valid4", {31'd0, v4}, 32'd0);
    check_val("mid_data4", d4, 32'd0);
    check_val("mid_active1", {31'd0, a1}, 32'd0);
    check_val("mid_data1", d1, 32'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nidle, nw;
    reset_L = 1'b0;
    data_in = 1'b0;
    #2;

    // Acquisition, data path and gap pattern, then reset mid-word.
    do_reset();
    push_noise(5);
    repeat (4) push_word(IDLE);
    push_word(32'hEEEEEEEE);
    push_word(32'hEEEEEEEF);
    push_word(IDLE);
    push_word(IDLE);
    push_word(rand_data());
    push_word(rand_data());
    push_noise(10);
    run_stream();
    check_val("locked_before_mid_reset", {31'd0, a4}, 32'd1);
    mid_reset();

    // Failed lock: a data word breaks the idle run inside CHECK.
    do_reset();
    push_noise(3);
    push_word(IDLE);
    push_word(IDLE);
    push_word(32'h12345678);
    repeat (4) push_word(IDLE);
    push_word(rand_data());
    push_word(IDLE);
    push_word(rand_data());
    run_stream();

    // Randomized streams: noise, a random-length idle run, random mix.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      push_noise($urandom_range(0, 40));
      nidle = $urandom_range(1, 6);
      repeat (nidle) push_word(IDLE);
      nw = $urandom_range(4, 10);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 2) == 0) push_word(IDLE);
        else push_word(rand_data());
      end
      push_noise($urandom_range(0, 31));
      run_stream();
      if ($urandom_range(0, 1) == 1) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
